// File: rtl/uart_matrix_formatter_pkg.sv
// Shared constants, FSM encoding and helpers for the matrix-to-UART text formatter.
package uart_matrix_formatter_pkg;

  localparam int unsigned MAX_DIM = 5;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DIM_W   = 3;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [BYTE_W-1:0] ASC_0     = 8'h30;
  localparam logic [BYTE_W-1:0] ASC_A     = 8'h41;
  localparam logic [BYTE_W-1:0] ASC_MINUS = 8'h2D;
  localparam logic [BYTE_W-1:0] ASC_SP    = 8'h20;
  localparam logic [BYTE_W-1:0] ASC_M     = 8'h4D;
  localparam logic [BYTE_W-1:0] ASC_E     = 8'h45;
  localparam logic [BYTE_W-1:0] ASC_R     = 8'h52;
  localparam logic [BYTE_W-1:0] ASC_CR    = 8'h0D;
  localparam logic [BYTE_W-1:0] ASC_LF    = 8'h0A;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_HDR,
    ST_ERR_TX,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_CONV,
    ST_SEND_SIGN,
    ST_SEND_DIG,
    ST_SEP,
    ST_TX_ISSUE,
    ST_TX_WAIT,
    ST_DONE
  } state_e;

  function automatic logic [BYTE_W-1:0] hex_ascii(input logic [3:0] v);
    return (v < 4'd10) ? ASC_0 + BYTE_W'(v) : ASC_A + BYTE_W'(v) - 8'd10;
  endfunction

endpackage

// File: rtl/uart_matrix_formatter_bin_to_dec_ascii.sv
// Signed 8-bit to decimal ASCII: sign flag, hundreds/tens/ones digits and digit count.
module bin_to_dec_ascii
  import uart_matrix_formatter_pkg::*;
(
  input  logic [BYTE_W-1:0]        val_i,
  output logic                     neg_o,
  output logic [2:0][BYTE_W-1:0]   dig_o,
  output logic [1:0]               cnt_o
);

  logic [8:0] mag;
  logic [8:0] rem;
  logic       hund;
  logic [3:0] tens;

  // 9-bit magnitude keeps -128 representable; tens found by repeated subtract of 10
  always_comb begin
    neg_o = val_i[7];
    mag   = val_i[7] ? 9'(~{val_i[7], val_i}) + 9'd1 : {1'b0, val_i};
    hund  = 1'b0;
    rem   = mag;
    tens  = 4'd0;
    if (rem >= 9'd100) begin
      hund = 1'b1;
      rem  = rem - 9'd100;
    end
    for (int k = 0; k < 9; k++) begin
      if (rem >= 9'd10) begin
        rem  = rem - 9'd10;
        tens = tens + 4'd1;
      end
    end
    dig_o[2] = ASC_0 + BYTE_W'(hund);
    dig_o[1] = ASC_0 + BYTE_W'(tens);
    dig_o[0] = ASC_0 + BYTE_W'(rem);
    cnt_o    = hund ? 2'd3 : ((tens != 4'd0) ? 2'd2 : 2'd1);
  end

endmodule

// File: rtl/uart_matrix_formatter.sv
// Reads a stored matrix element by element and streams it as decimal text to uart_tx.
module uart_matrix_formatter
  import uart_matrix_formatter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [3:0]        matrix_id_i,
  input  logic [DIM_W-1:0]  dim_m_i,
  input  logic [DIM_W-1:0]  dim_n_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [BYTE_W-1:0] rd_data_i,
  output logic [BYTE_W-1:0] tx_data_o,
  output logic              tx_start_o,
  input  logic              tx_busy_i,
  output logic              busy_o,
  output logic              done_o
);

  state_e                   state_q, state_d, ret_q, ret_d;
  logic [3:0]               id_q, id_d;
  logic [DIM_W-1:0]         m_q, m_d, n_q, n_d, row_q, row_d, col_q, col_d;
  logic [2:0]               idx_q, idx_d;
  logic                     lf_q, lf_d, skip_q, skip_d, neg_q, neg_d;
  logic [2:0][BYTE_W-1:0]   dig_q, dig_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [BYTE_W-1:0]        val_q, val_d, tx_data_q, tx_data_d;
  logic                     rd_en_q, rd_en_d, tx_start_q, tx_start_d;
  logic                     busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;

  logic                     conv_neg;
  logic [2:0][BYTE_W-1:0]   conv_dig;
  logic [1:0]               conv_cnt;
  logic [1:0]               dig_pos;
  logic [BYTE_W-1:0]        dig_byte;

  bin_to_dec_ascii u_b2d (
    .val_i (val_q),
    .neg_o (conv_neg),
    .dig_o (conv_dig),
    .cnt_o (conv_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ret_q      <= ST_IDLE;
      id_q       <= '0;
      m_q        <= '0;
      n_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      idx_q      <= '0;
      lf_q       <= 1'b0;
      skip_q     <= 1'b0;
      neg_q      <= 1'b0;
      dig_q      <= '0;
      cnt_q      <= '0;
      val_q      <= '0;
      tx_data_q  <= '0;
      rd_en_q    <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      id_q       <= id_d;
      m_q        <= m_d;
      n_q        <= n_d;
      row_q      <= row_d;
      col_q      <= col_d;
      idx_q      <= idx_d;
      lf_q       <= lf_d;
      skip_q     <= skip_d;
      neg_q      <= neg_d;
      dig_q      <= dig_d;
      cnt_q      <= cnt_d;
      val_q      <= val_d;
      tx_data_q  <= tx_data_d;
      rd_en_q    <= rd_en_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  // Sequencer states pick a byte and a return state; TX_ISSUE/TX_WAIT run the uart handshake
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    id_d       = id_q;
    m_d        = m_q;
    n_d        = n_q;
    row_d      = row_q;
    col_d      = col_q;
    idx_d      = idx_q;
    lf_d       = lf_q;
    skip_d     = skip_q;
    neg_d      = neg_q;
    dig_d      = dig_q;
    cnt_d      = cnt_q;
    val_d      = val_q;
    tx_data_d  = tx_data_q;
    rd_addr_d  = rd_addr_q;
    tx_start_d = 1'b0;

    dig_pos = cnt_q - 2'd1 - idx_q[1:0];
    case (dig_pos)
      2'd2:    dig_byte = dig_q[2];
      2'd1:    dig_byte = dig_q[1];
      default: dig_byte = dig_q[0];
    endcase

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          id_d    = matrix_id_i;
          m_d     = dim_m_i;
          n_d     = dim_n_i;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        idx_d     = '0;
        row_d     = '0;
        col_d     = '0;
        lf_d      = 1'b0;
        rd_addr_d = '0;
        if (m_q == '0 || n_q == '0 || m_q > DIM_W'(MAX_DIM) || n_q > DIM_W'(MAX_DIM))
          state_d = ST_ERR_TX;
        else
          state_d = ST_HDR;
      end
      ST_HDR: begin
        case (idx_q)
          3'd0:    tx_data_d = ASC_M;
          3'd1:    tx_data_d = hex_ascii(id_q);
          3'd2:    tx_data_d = ASC_SP;
          3'd3:    tx_data_d = ASC_0 + BYTE_W'(m_q);
          3'd4:    tx_data_d = ASC_SP;
          3'd5:    tx_data_d = ASC_0 + BYTE_W'(n_q);
          3'd6:    tx_data_d = ASC_CR;
          default: tx_data_d = ASC_LF;
        endcase
        idx_d   = idx_q + 3'd1;
        ret_d   = (idx_q == 3'd7) ? ST_RD_REQ : ST_HDR;
        state_d = ST_TX_ISSUE;
      end
      ST_ERR_TX: begin
        case (idx_q)
          3'd0:    tx_data_d = ASC_E;
          3'd1:    tx_data_d = ASC_R;
          3'd2:    tx_data_d = ASC_R;
          3'd3:    tx_data_d = ASC_CR;
          default: tx_data_d = ASC_LF;
        endcase
        idx_d   = idx_q + 3'd1;
        ret_d   = (idx_q == 3'd4) ? ST_DONE : ST_ERR_TX;
        state_d = ST_TX_ISSUE;
      end
      ST_RD_REQ: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        val_d     = rd_data_i;
        rd_addr_d = rd_addr_q + ADDR_W'(1);
        state_d   = ST_CONV;
      end
      ST_CONV: begin
        neg_d   = conv_neg;
        dig_d   = conv_dig;
        cnt_d   = conv_cnt;
        idx_d   = '0;
        state_d = conv_neg ? ST_SEND_SIGN : ST_SEND_DIG;
      end
      ST_SEND_SIGN: begin
        tx_data_d = ASC_MINUS;
        ret_d     = ST_SEND_DIG;
        state_d   = ST_TX_ISSUE;
      end
      ST_SEND_DIG: begin
        tx_data_d = dig_byte;
        if (idx_q == {1'b0, cnt_q} - 3'd1) begin
          idx_d = '0;
          ret_d = ST_SEP;
        end else begin
          idx_d = idx_q + 3'd1;
          ret_d = ST_SEND_DIG;
        end
        state_d = ST_TX_ISSUE;
      end
      ST_SEP: begin
        if (col_q != n_q - DIM_W'(1)) begin
          tx_data_d = ASC_SP;
          col_d     = col_q + DIM_W'(1);
          ret_d     = ST_RD_REQ;
        end else if (!lf_q) begin
          tx_data_d = ASC_CR;
          lf_d      = 1'b1;
          ret_d     = ST_SEP;
        end else begin
          tx_data_d = ASC_LF;
          lf_d      = 1'b0;
          col_d     = '0;
          row_d     = row_q + DIM_W'(1);
          ret_d     = (row_q == m_q - DIM_W'(1)) ? ST_DONE : ST_RD_REQ;
        end
        state_d = ST_TX_ISSUE;
      end
      ST_TX_ISSUE: begin
        if (!tx_busy_i) begin
          tx_start_d = 1'b1;
          skip_d     = 1'b1;
          state_d    = ST_TX_WAIT;
        end
      end
      // First cycle is the tx_start cycle, before uart_tx can raise busy
      ST_TX_WAIT: begin
        if (skip_q)          skip_d  = 1'b0;
        else if (!tx_busy_i) state_d = ret_q;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    rd_en_d = (state_d == ST_RD_REQ);
    done_d  = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  assign rd_en_o    = rd_en_q;
  assign rd_addr_o  = rd_addr_q;
  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_uart_matrix_formatter.sv
// Bench for uart_matrix_formatter: storage and uart_tx models, text-level reference model.
module tb_uart_matrix_formatter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] matrix_id = '0;
  logic [2:0] dim_m = '0;
  logic [2:0] dim_n = '0;
  logic       rd_en;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  uart_matrix_formatter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .matrix_id_i (matrix_id),
    .dim_m_i     (dim_m),
    .dim_n_i     (dim_n),
    .rd_en_o     (rd_en),
    .rd_addr_o   (rd_addr),
    .rd_data_i   (rd_data),
    .tx_data_o   (tx_data),
    .tx_start_o  (tx_start),
    .tx_busy_i   (tx_busy),
    .busy_o      (busy),
    .done_o      (done)
  );

  logic [7:0] mem [0:31];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // uart_tx model: busy from the cycle after tx_start for a random time, or one long stall
  int bcnt;
  int byte_no;
  int stall_at = -1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      bcnt    <= 0;
      byte_no <= 0;
    end else if (tx_start) begin
      tx_busy <= 1'b1;
      bcnt    <= (byte_no == stall_at) ? 1000 : int'($urandom_range(1, 20));
      byte_no <= byte_no + 1;
    end else if (bcnt > 1) begin
      bcnt <= bcnt - 1;
    end else if (bcnt == 1) begin
      bcnt    <= 0;
      tx_busy <= 1'b0;
    end
  end

  logic [7:0] rx_q[$];
  int         rd_q[$];
  int         done_cnt = 0;
  int         proto_err = 0;
  logic       prev_start = 1'b0;
  always @(negedge clk) begin
    if (tx_start) begin
      rx_q.push_back(tx_data);
      if (tx_busy) proto_err++;
      if (prev_start) proto_err++;
    end
    prev_start = tx_start;
    if (rd_en) rd_q.push_back(int'(rd_addr));
    if (done) done_cnt++;
  end

  int total = 0;
  int bad = 0;

  function automatic string show(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'd13)      r = {r, "~"};
      else if (s[i] == 8'd10) r = {r, "|"};
      else                    r = {r, s.substr(i, i)};
    end
    return r;
  endfunction

  function automatic string crlf();
    return $sformatf("%c%c", 8'd13, 8'd10);
  endfunction

  function automatic string conv(input string x);
    string r = "";
    for (int i = 0; i < x.len(); i++) begin
      if (x[i] == 8'h7C) r = {r, crlf()};
      else               r = {r, x.substr(i, i)};
    end
    return r;
  endfunction

  // Reference: text rendering of the matrix held in mem, row-major
  function automatic string model(input int id, input int m, input int n);
    string hexs = "0123456789ABCDEF";
    string s;
    if (m < 1 || m > 5 || n < 1 || n > 5) return {"ERR", crlf()};
    s = {"M", hexs.substr(id, id), $sformatf(" %0d %0d", m, n), crlf()};
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        s = {s, $sformatf("%0d", int'($signed(mem[r * n + c])))};
        if (c != n - 1) s = {s, " "};
      end
      s = {s, crlf()};
    end
    return s;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic chk_str(input string name, input string got, input string exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=\"%s\" exp=\"%s\"", name, show(got), show(exp));
    end
  endtask

  function automatic string rx_text(input int from);
    string s = "";
    for (int k = from; k < rx_q.size(); k++) s = {s, $sformatf("%c", rx_q[k])};
    return s;
  endfunction

  task automatic run_txn(input int id, input int m, input int n, input int restart_at,
                         input bit poke_done, output string got);
    int  b0, r0, d0, busy_bad, addr_bad, exp_rd;
    bit  seen;
    b0 = rx_q.size(); r0 = rd_q.size(); d0 = done_cnt;
    busy_bad = 0; addr_bad = 0; seen = 1'b0;
    @(negedge clk);
    matrix_id = 4'(id); dim_m = 3'(m); dim_n = 3'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    matrix_id = 4'($urandom); dim_m = 3'($urandom); dim_n = 3'($urandom);
    for (int cyc = 0; cyc < 30000; cyc++) begin
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!busy) busy_bad++;
      if (cyc == restart_at) begin
        start = 1'b1; dim_m = 3'd5; dim_n = 3'd5; matrix_id = 4'd14;
      end
      @(negedge clk);
    end
    if (!seen) $display("FAIL done_timeout id=%0d m=%0d n=%0d", id, m, n);
    chk("done_seen", int'(seen), 1);
    chk("busy_low_at_done", int'(busy), 0);
    chk("busy_held", busy_bad, 0);
    if (poke_done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_in_done_ignored", int'(busy), 0);
    end
    repeat (5) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    exp_rd = (m >= 1 && m <= 5 && n >= 1 && n <= 5) ? m * n : 0;
    chk("rd_count", rd_q.size() - r0, exp_rd);
    for (int k = r0; k < rd_q.size(); k++) if (rd_q[k] != k - r0) addr_bad++;
    chk("rd_addr_seq", addr_bad, 0);
    got = rx_text(b0);
  endtask

  typedef struct {
    int    id;
    int    m;
    int    n;
    int    el[6];
    string exp;
  } vec_t;

  vec_t  vecs[6];
  string got;

  initial begin
    vecs[0] = '{3,  2, 2, '{1, -2, 10, 127, 0, 0},     "M3 2 2|1 -2|10 127|"};
    vecs[1] = '{10, 1, 3, '{0, -128, -1, 0, 0, 0},     "MA 1 3|0 -128 -1|"};
    vecs[2] = '{0,  0, 3, '{5, 5, 5, 5, 5, 5},         "ERR|"};
    vecs[3] = '{7,  2, 6, '{5, 5, 5, 5, 5, 5},         "ERR|"};
    vecs[4] = '{15, 1, 1, '{100, 0, 0, 0, 0, 0},       "MF 1 1|100|"};
    vecs[5] = '{9,  3, 1, '{-100, 99, 5, 0, 0, 0},     "M9 3 1|-100|99|5|"};

    repeat (3) @(negedge clk);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 32; k++) mem[k] = (k < 6) ? 8'(vecs[i].el[k]) : 8'($urandom);
      run_txn(vecs[i].id, vecs[i].m, vecs[i].n, -1, (i == 0), got);
      chk_str($sformatf("vec%0d_text", i), got, conv(vecs[i].exp));
      chk_str($sformatf("vec%0d_model", i), got, model(vecs[i].id, vecs[i].m, vecs[i].n));
    end

    // second start mid-stream must not disturb the running print
    for (int k = 0; k < 4; k++) mem[k] = 8'(vecs[0].el[k]);
    run_txn(3, 2, 2, 20, 1'b0, got);
    chk_str("restart_ignored", got, conv(vecs[0].exp));

    for (int t = 0; t < 6; t++) begin
      int m, n, id;
      m = int'($urandom_range(1, 5)); n = int'($urandom_range(1, 5)); id = int'($urandom_range(0, 15));
      for (int k = 0; k < 32; k++) mem[k] = 8'($urandom);
      if (t == 2) stall_at = byte_no + 5;
      run_txn(id, m, n, -1, 1'b0, got);
      chk_str($sformatf("rand%0d_model", t), got, model(id, m, n));
    end

    // reset during the second row, then a clean reprint
    begin
      int b0, lfs, hold;
      bit hit;
      for (int k = 0; k < 32; k++) mem[k] = 8'h80;
      b0 = rx_q.size(); hit = 1'b0;
      @(negedge clk);
      matrix_id = 4'd6; dim_m = 3'd3; dim_n = 3'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 20000; cyc++) begin
        lfs = 0;
        for (int k = b0; k < rx_q.size(); k++) if (rx_q[k] == 8'd10) lfs++;
        if (lfs >= 2) begin
          hit = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!hit) $display("FAIL row2_timeout");
      repeat (20) @(negedge clk);
      lfs = 0;
      for (int k = b0; k < rx_q.size(); k++) if (rx_q[k] == 8'd10) lfs++;
      chk("reset_in_row2", lfs, 2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rd_en", int'(rd_en), 0);
      chk("mid_rst_rd_addr", int'(rd_addr), 0);
      chk("mid_rst_tx_data", int'(tx_data), 0);
      chk("mid_rst_tx_start", int'(tx_start), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
      hold = rx_q.size();
      repeat (5) @(negedge clk);
      chk("no_bytes_in_reset", rx_q.size() - hold, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 32; k++) mem[k] = 8'($urandom);
      run_txn(6, 3, 3, -1, 1'b0, got);
      chk_str("after_reset_model", got, model(6, 3, 3));
    end

    chk("tx_protocol", proto_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
